i2c_ctrl_slave: RTL and testbench

- I2C responder (slave) on the SDA/SCL pair, the other end of the I2C master used for the clock generator.
- Lets an external controller board read and write the receiver control set over I2C, as an alternative to USB: rx_freq, att, rx_on, bs_on.
- Control outputs feed the same consumers as the USB control path (attenuator, bpf_ctrl, receiver).
- Runs in the clock_02 domain; the top-level mux that selects between USB and I2C control is outside this block.

---
 rtl/i2c_ctrl_slave_if.sv | 23 ++
 rtl/i2c_ctrl_slave.sv | 248 ++++++++++++++++++++++++
 tb/tb_i2c_ctrl_slave.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_ctrl_slave_if.sv
// I2C pad levels plus the receiver control set exchanged with the i2c_ctrl_slave responder.
interface i2c_ctrl_slave_if;
  logic        scl_in;
  logic        sda_in;
  logic        sda_oe;
  logic        clip;
  logic [31:0] rx_freq;
  logic [7:0]  att;
  logic        rx_on;
  logic        bs_on;
  logic        upd;
  logic        busy;

  modport slave (
    input  scl_in, sda_in, clip,
    output sda_oe, rx_freq, att, rx_on, bs_on, upd, busy
  );

  modport master (
    output scl_in, sda_in, clip,
    input  sda_oe, rx_freq, att, rx_on, bs_on, upd, busy
  );
endinterface

// File: rtl/i2c_ctrl_slave.sv
// I2C responder exposing rx_freq/att/rx_on/bs_on plus firmware digits; rx_freq commits atomically
// at STOP or repeated START so the receiver never sees a half-written frequency.
module i2c_ctrl_slave #(
  parameter logic [6:0]  ADDR = 7'h2C,
  parameter int unsigned FILT = 3,
  parameter logic [7:0]  FW1  = "1",
  parameter logic [7:0]  FW2  = "5"
) (
  input logic             clock,
  input logic             reset,
  i2c_ctrl_slave_if.slave bus
);

  localparam int unsigned CW = (FILT > 1) ? $clog2(FILT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
  } state_t;

  // index 0 = SCL, index 1 = SDA
  logic [1:0]    r_meta;
  logic [1:0]    r_sync;
  logic [1:0]    r_filt;
  logic [1:0]    r_filt_d;
  logic [CW-1:0] r_cnt [2];
  logic          r_armed;

  state_t      r_state;
  logic [3:0]  r_bits;
  logic [7:0]  r_sh;
  logic [2:0]  r_ptr;
  logic        r_rw;
  logic [31:0] r_shadow;
  logic        r_fdirty;
  logic [31:0] r_rx_freq;
  logic [7:0]  r_att;
  logic        r_rx_on;
  logic        r_bs_on;
  logic        r_upd;
  logic        r_busy;
  logic        r_sda_oe;

  logic       w_scl;
  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [2:0] w_ptr_nx;
  logic [7:0] w_regs [8];
  logic [7:0] w_rd_cur;
  logic [7:0] w_rd_nxt;

  // Synchronise, then accept a new level only after FILT consecutive agreeing samples
  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_filt   <= '0;
      r_filt_d <= '0;
      r_armed  <= 1'b0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_meta   <= {bus.sda_in, bus.scl_in};
      r_sync   <= r_meta;
      r_filt_d <= r_filt;
      if (&r_filt) r_armed <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(FILT - 1)) begin
          r_filt[i] <= r_sync[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Bus events are masked until both lines have been seen idle-high after reset
  assign w_scl      = r_filt[0];
  assign w_sda      = r_filt[1];
  assign w_scl_rise = r_armed &  w_scl & ~r_filt_d[0];
  assign w_scl_fall = r_armed & ~w_scl &  r_filt_d[0];
  assign w_start    = r_armed & w_scl & r_filt_d[0] & ~w_sda &  r_filt_d[1];
  assign w_stop     = r_armed & w_scl & r_filt_d[0] &  w_sda & ~r_filt_d[1];
  assign w_ptr_nx   = r_ptr + 3'd1;

  always_comb begin
    w_regs[0] = r_rx_freq[7:0];
    w_regs[1] = r_rx_freq[15:8];
    w_regs[2] = r_rx_freq[23:16];
    w_regs[3] = r_rx_freq[31:24];
    w_regs[4] = r_att;
    w_regs[5] = {bus.clip, 5'b00000, r_bs_on, r_rx_on};
    w_regs[6] = FW1;
    w_regs[7] = FW2;
  end

  assign w_rd_cur = w_regs[r_ptr];
  assign w_rd_nxt = w_regs[w_ptr_nx];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bits    <= '0;
      r_sh      <= '0;
      r_ptr     <= '0;
      r_rw      <= 1'b0;
      r_shadow  <= '0;
      r_fdirty  <= 1'b0;
      r_rx_freq <= '0;
      r_att     <= '0;
      r_rx_on   <= 1'b0;
      r_bs_on   <= 1'b0;
      r_upd     <= 1'b0;
      r_busy    <= 1'b0;
      r_sda_oe  <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (w_start || w_stop) begin
        if (r_fdirty) begin
          r_rx_freq <= r_shadow;
          r_fdirty  <= 1'b0;
          r_upd     <= 1'b1;
        end
        r_sda_oe <= 1'b0;
        r_bits   <= '0;
        if (w_stop) begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end else begin
          r_state <= S_ADDR;
        end
      end else if (w_scl_rise) begin
        case (r_state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (r_bits != 4'd8) begin
              r_sh   <= {r_sh[6:0], w_sda};
              r_bits <= r_bits + 4'd1;
            end
          end
          S_RDATA_ACK: if (w_sda) r_state <= S_IDLE;
          default: ;
        endcase
      end else if (w_scl_fall) begin
        case (r_state)
          S_ADDR: begin
            if (r_bits == 4'd8) begin
              r_bits <= '0;
              if (r_sh[7:1] == ADDR) begin
                r_rw     <= r_sh[0];
                r_busy   <= 1'b1;
                r_sda_oe <= 1'b1;
                r_state  <= S_ADDR_ACK;
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
          S_ADDR_ACK: begin
            r_bits <= '0;
            if (r_rw) begin
              r_sh     <= w_rd_cur;
              r_sda_oe <= ~w_rd_cur[7];
              r_state  <= S_RDATA;
            end else begin
              r_sda_oe <= 1'b0;
              r_state  <= S_PTR;
            end
          end
          S_PTR: begin
            if (r_bits == 4'd8) begin
              r_ptr    <= r_sh[2:0];
              r_bits   <= '0;
              r_sda_oe <= 1'b1;
              r_state  <= S_PTR_ACK;
            end
          end
          S_PTR_ACK: begin
            r_sda_oe <= 1'b0;
            r_state  <= S_WDATA;
          end
          S_WDATA: begin
            if (r_bits == 4'd8) begin
              r_bits   <= '0;
              r_sda_oe <= 1'b1;
              r_state  <= S_WDATA_ACK;
              case (r_ptr)
                3'd0, 3'd1, 3'd2, 3'd3: begin
                  r_shadow[{r_ptr[1:0], 3'b000} +: 8] <= r_sh;
                  r_fdirty <= 1'b1;
                end
                3'd4: begin
                  r_att <= r_sh;
                  r_upd <= 1'b1;
                end
                3'd5: begin
                  r_rx_on <= r_sh[0];
                  r_bs_on <= r_sh[1];
                  r_upd   <= 1'b1;
                end
                default: ;
              endcase
            end
          end
          S_WDATA_ACK: begin
            r_sda_oe <= 1'b0;
            r_ptr    <= w_ptr_nx;
            r_state  <= S_WDATA;
          end
          S_RDATA: begin
            if (r_bits == 4'd7) begin
              r_sda_oe <= 1'b0;
              r_bits   <= '0;
              r_state  <= S_RDATA_ACK;
            end else begin
              r_sh     <= {r_sh[6:0], 1'b0};
              r_sda_oe <= ~r_sh[6];
              r_bits   <= r_bits + 4'd1;
            end
          end
          // Reached only after the master ACKed; a NACK already returned to IDLE on the rise
          S_RDATA_ACK: begin
            r_ptr    <= w_ptr_nx;
            r_sh     <= w_rd_nxt;
            r_sda_oe <= ~w_rd_nxt[7];
            r_bits   <= '0;
            r_state  <= S_RDATA;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_oe  = r_sda_oe;
  assign bus.rx_freq = r_rx_freq;
  assign bus.att     = r_att;
  assign bus.rx_on   = r_rx_on;
  assign bus.bs_on   = r_bs_on;
  assign bus.upd     = r_upd;
  assign bus.busy    = r_busy;

endmodule

// File: tb/tb_i2c_ctrl_slave.sv
// Bit-banged I2C master driving i2c_ctrl_slave, checked against a register-level model of the control set.
module tb_i2c_ctrl_slave;
  localparam int unsigned Q     = 8;
  localparam logic [6:0]  SADDR = 7'h2C;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic clip_r = 1'b0;

  i2c_ctrl_slave_if bus();
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;
  assign bus.clip   = clip_r;

  i2c_ctrl_slave #(.ADDR(SADDR), .FILT(3), .FW1("1"), .FW2("5")) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  int upd_cnt  = 0;
  int oe_cnt   = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (bus.upd === 1'b1)    upd_cnt++;
    if (bus.sda_oe === 1'b1) oe_cnt++;
    if (bus.busy === 1'b1)   busy_cnt++;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Register-level model of the control set
  logic [31:0] m_freq;
  logic [31:0] m_shadow;
  logic        m_dirty;
  logic [7:0]  m_att;
  logic        m_rxon;
  logic        m_bson;
  int          m_upd = 0;

  task automatic m_reset();
    m_freq = '0; m_shadow = '0; m_dirty = 1'b0;
    m_att = '0; m_rxon = 1'b0; m_bson = 1'b0;
  endtask

  task automatic m_write(input logic [2:0] p, input logic [7:0] d);
    if (p < 3'd4) begin
      m_shadow[int'(p)*8 +: 8] = d;
      m_dirty = 1'b1;
    end else if (p == 3'd4) begin
      m_att = d; m_upd++;
    end else if (p == 3'd5) begin
      m_rxon = d[0]; m_bson = d[1]; m_upd++;
    end
  endtask

  task automatic m_end();
    if (m_dirty) begin
      m_freq = m_shadow; m_dirty = 1'b0; m_upd++;
    end
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] p);
    logic [7:0] v;
    if (p < 3'd4)       v = m_freq[int'(p)*8 +: 8];
    else if (p == 3'd4) v = m_att;
    else if (p == 3'd5) v = {clip_r, 5'b00000, m_bson, m_rxon};
    else if (p == 3'd6) v = 8'h31;
    else                v = 8'h35;
    return v;
  endfunction

  // Bus-level master
  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wt(Q); scl_m = 1'b1; wt(Q); sda_m = 1'b0; wt(Q); scl_m = 1'b0; wt(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wt(Q); scl_m = 1'b1; wt(Q); sda_m = 1'b1; wt(2*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wt(Q);
      if (glitch && i == 4) begin scl_m = 1'b1; wt(1); scl_m = 1'b0; wt(Q/2); end
      scl_m = 1'b1; wt(Q);
      if (glitch && i == 3) begin sda_m = ~b[i]; wt(1); sda_m = b[i]; end
      wt(Q); scl_m = 1'b0; wt(Q);
    end
    sda_m = 1'b1; wt(Q); scl_m = 1'b1; wt(Q); ack = bus.sda_in; wt(Q); scl_m = 1'b0; wt(Q);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wt(Q); scl_m = 1'b1; wt(Q); d[i] = bus.sda_in; wt(Q); scl_m = 1'b0;
    end
    wt(2); sda_m = mack; wt(Q-2); scl_m = 1'b1; wt(2*Q); scl_m = 1'b0; wt(2); sda_m = 1'b1; wt(Q-2);
  endtask

  logic [7:0] wbuf [8];
  logic [7:0] rbuf [8];

  task automatic do_write(input logic [7:0] ptr, input int n, input bit stop, input bit glitch);
    logic ack;
    logic [2:0] p;
    i2c_start();
    send_byte({SADDR, 1'b0}, 1'b0, ack); chk("wr_addr_ack", 32'(ack), 32'd0);
    send_byte(ptr, 1'b0, ack);           chk("wr_ptr_ack", 32'(ack), 32'd0);
    p = ptr[2:0];
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], glitch, ack);
      chk($sformatf("wr_data_ack%0d", i), 32'(ack), 32'd0);
      m_write(p, wbuf[i]);
      p = p + 3'd1;
    end
    if (stop) begin i2c_stop(); m_end(); end
  endtask

  task automatic do_read(input logic [7:0] ptr, input int n);
    logic ack;
    logic [2:0] p;
    logic [7:0] d;
    i2c_start();
    send_byte({SADDR, 1'b0}, 1'b0, ack); chk("rd_waddr_ack", 32'(ack), 32'd0);
    send_byte(ptr, 1'b0, ack);           chk("rd_ptr_ack", 32'(ack), 32'd0);
    i2c_start(); m_end();
    send_byte({SADDR, 1'b1}, 1'b0, ack); chk("rd_raddr_ack", 32'(ack), 32'd0);
    p = ptr[2:0];
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n - 1, d);
      rbuf[i] = d;
      chk($sformatf("rd_reg%0d", p), 32'(d), 32'(m_read(p)));
      p = p + 3'd1;
    end
    i2c_stop(); m_end();
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_rx_freq"}, bus.rx_freq, m_freq);
    chk({tag, "_att"},     32'(bus.att), 32'(m_att));
    chk({tag, "_rx_on"},   32'(bus.rx_on), 32'(m_rxon));
    chk({tag, "_bs_on"},   32'(bus.bs_on), 32'(m_bson));
    chk({tag, "_busy"},    32'(bus.busy), 32'd0);
    chk({tag, "_sda_oe"},  32'(bus.sda_oe), 32'd0);
    chk({tag, "_upd_cnt"}, 32'(upd_cnt), 32'(m_upd));
  endtask

  task automatic write_freq_scenario(input string tag);
    int u0;
    wbuf[0] = 8'h40; wbuf[1] = 8'hE3; wbuf[2] = 8'h80; wbuf[3] = 8'h00;
    do_write(8'h00, 4, 1'b0, 1'b0);
    chk({tag, "_freq_before_stop"}, bus.rx_freq, m_freq);
    chk({tag, "_busy_before_stop"}, 32'(bus.busy), 32'd1);
    u0 = upd_cnt;
    i2c_stop(); m_end();
    chk({tag, "_freq_after_stop"}, bus.rx_freq, 32'h0080E340);
    chk({tag, "_upd_pulses"}, 32'(upd_cnt - u0), 32'd1);
    check_outputs(tag);
  endtask

  typedef struct {
    logic [7:0] ptr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic ack;
    int   oe0, busy0;
    logic [7:0] ptr;
    int   n;

    tbl[0] = '{8'h04, 8'h5A, 8'h5A};
    tbl[1] = '{8'h05, 8'hFF, 8'h03};
    tbl[2] = '{8'h05, 8'h00, 8'h00};
    tbl[3] = '{8'h06, 8'h00, 8'h31};
    tbl[4] = '{8'h07, 8'hFF, 8'h35};
    tbl[5] = '{8'h0C, 8'hC3, 8'hC3};
    tbl[6] = '{8'h80, 8'h77, 8'h77};

    m_reset();
    rst = 1'b1; wt(5);
    chk("rst_sda_oe",  32'(bus.sda_oe), 32'd0);
    chk("rst_rx_freq", bus.rx_freq, 32'd0);
    chk("rst_att",     32'(bus.att), 32'd0);
    chk("rst_rx_on",   32'(bus.rx_on), 32'd0);
    chk("rst_bs_on",   32'(bus.bs_on), 32'd0);
    chk("rst_upd",     32'(bus.upd), 32'd0);
    chk("rst_busy",    32'(bus.busy), 32'd0);
    rst = 1'b0; wt(20);

    // Atomic 4-byte frequency write
    write_freq_scenario("freq");

    // reg5 write with read-only bit7, then read back 3 bytes with clip set
    clip_r = 1'b1;
    wbuf[0] = 8'h83;
    do_write(8'h05, 1, 1'b1, 1'b0);
    chk("reg5_rx_on", 32'(bus.rx_on), 32'd1);
    chk("reg5_bs_on", 32'(bus.bs_on), 32'd1);
    do_read(8'h05, 3);
    chk("rd3_byte0", 32'(rbuf[0]), 32'h83);
    chk("rd3_byte1", 32'(rbuf[1]), 32'h31);
    chk("rd3_byte2", 32'(rbuf[2]), 32'h35);
    check_outputs("rd3");
    clip_r = 1'b0;

    // Wrong address: never ACKed, SDA never pulled, busy never raised
    oe0 = oe_cnt; busy0 = busy_cnt;
    i2c_start();
    send_byte({7'h2D, 1'b0}, 1'b0, ack);
    chk("badaddr_nack", 32'(ack), 32'd1);
    send_byte(8'h04, 1'b0, ack);
    chk("badaddr_data_nack", 32'(ack), 32'd1);
    i2c_stop();
    chk("badaddr_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
    chk("badaddr_busy_cycles", 32'(busy_cnt - busy0), 32'd0);
    check_outputs("badaddr");

    // Pointer wrap 7 -> 0
    wbuf[0] = 8'hAA; wbuf[1] = 8'h11;
    do_write(8'h07, 2, 1'b1, 1'b0);
    chk("wrap_freq_b0", 32'(bus.rx_freq[7:0]), 32'h11);
    do_read(8'h07, 1);
    chk("wrap_fw2", 32'(rbuf[0]), 32'h35);
    check_outputs("wrap");

    // Single-clock glitches on SCL and SDA mid-byte
    wbuf[0] = 8'h3C;
    do_write(8'h04, 1, 1'b1, 1'b1);
    chk("glitch_att", 32'(bus.att), 32'h3C);
    do_read(8'h04, 1);
    check_outputs("glitch");

    // Reset after 2 of 4 frequency bytes
    i2c_start();
    send_byte({SADDR, 1'b0}, 1'b0, ack);
    send_byte(8'h00, 1'b0, ack);
    send_byte(8'h12, 1'b0, ack);
    send_byte(8'h34, 1'b0, ack);
    rst = 1'b1; wt(3);
    chk("midrst_sda_oe",  32'(bus.sda_oe), 32'd0);
    chk("midrst_rx_freq", bus.rx_freq, 32'd0);
    rst = 1'b0; m_reset();
    sda_m = 1'b1; scl_m = 1'b1; wt(4*Q);
    chk("midrst_freq_held", bus.rx_freq, 32'd0);
    check_outputs("midrst");
    write_freq_scenario("postrst");

    // Table-driven single-register write/readback
    for (int t = 0; t < 7; t++) begin
      wbuf[0] = tbl[t].wdata;
      do_write(tbl[t].ptr, 1, 1'b1, 1'b0);
      do_read(tbl[t].ptr, 1);
      chk($sformatf("tbl%0d_read", t), 32'(rbuf[0]), 32'(tbl[t].exp_rd));
    end
    check_outputs("tbl");

    // Randomised transactions against the model
    for (int k = 0; k < 12; k++) begin
      ptr    = 8'($urandom);
      n      = int'($urandom_range(1, 4));
      clip_r = 1'($urandom);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 0) do_write(ptr, n, 1'b1, 1'b0);
      else                           do_read(ptr, n);
      check_outputs($sformatf("rnd%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
